pipelined_barrel_shifter: RTL
=============================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 12, data word width in bits; legal range 2..64.
REQ-002 SHALL have derived localparam SHW = $clog2(WIDTH), shift-amount width and pipeline depth.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, input beat present.
REQ-006 SHALL have port in_ready, output, 1, input beat accepted when in_valid && in_ready.
REQ-007 SHALL have port data_in, input, WIDTH, operand.
REQ-008 SHALL have port shift_amt, input, SHW, shift distance.
REQ-009 SHALL have port dir, input, 1, 0 = left, 1 = right.
REQ-010 SHALL have port mode, input, 2, 00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts when out_valid && out_ready.
REQ-013 SHALL have port data_out, output, WIDTH, result.

Function
REQ-014 SHALL implement SHW cascaded mux levels (level k shifts by 2^k), each followed by a register; latency exactly SHW cycles from acceptance to out_valid with out_ready held high.
REQ-015 SHALL carry valid, dir, mode and the remaining shift_amt bits alongside data through every level.
REQ-016 SHALL use one global advance enable: adv = !out_valid || out_ready; in_ready = adv; all levels hold when adv = 0.
REQ-017 SHALL, while stalled, hold data_out and out_valid stable; no beat lost, duplicated or reordered.
REQ-018 SHALL fill vacated bits with 0 for logical shifts and for arithmetic left.
REQ-019 SHALL fill vacated bits with data_in[WIDTH-1] for arithmetic right.
REQ-020 SHALL rotate by shift_amt mod WIDTH in rotate mode.
REQ-021 SHALL, for logical/arithmetic with shift_amt >= WIDTH (non-power-of-2 WIDTH), output all fill bits (0 or sign).
REQ-022 SHALL pass data unchanged for shift_amt = 0 in every mode.
REQ-023 SHALL leave beats accepted before a stall in flight with valid bits cleared where bubbles exist; bubbles are not compressed.

Reset
REQ-024 SHALL, on rst = 1 at a clock edge, clear all stage valid bits; out_valid = 0, data_out = 0, in_ready = 1 the following cycle.
REQ-025 SHALL discard beats in flight on reset mid-operation; in_valid ignored while rst = 1.

Configuration
REQ-026 SHALL, with macro PBS_FLAGS_EN defined, add outputs out_zero (1, data_out == 0) and out_carry (1, last bit shifted out), pipelined with data.
REQ-027 SHALL compute out_carry: amt 0 -> 0; amt 1..WIDTH-1 left -> data_in[WIDTH-amt], right -> data_in[amt-1]; amt >= WIDTH -> 0 logical, sign for arithmetic right; rotate left -> data_out[0], right -> data_out[WIDTH-1], 0 if amt mod WIDTH = 0.
REQ-028 SHALL, without PBS_FLAGS_EN, omit both ports and their logic entirely.

Structure
REQ-029 SHALL place typedef enum shift_mode_t (MODE_LOGIC, MODE_ARITH, MODE_ROT, MODE_RSVD) and direction constants in package pbs_pkg.
REQ-030 SHALL use one sub-module pbs_stage (single mux level + register, parameter STAGE_SHIFT), instantiated SHW times via generate.

Verification (WIDTH = 12, latency 4)
REQ-031 SHALL check logical left 4 of 12'h5CE -> 12'hCE0 four cycles after acceptance; flags: carry 1, zero 0.
REQ-032 SHALL check arithmetic right 3 of 12'hA30 -> 12'hF46, carry 0; logical right 14 of 12'h5CE -> 12'h000, zero 1.
REQ-033 SHALL check rotate right 13 of 12'h5CE -> 12'h2E7 (equals rotate 1), carry 0.
REQ-034 SHALL check back-to-back beats with out_ready low 3 cycles: in_ready low, data_out stable, all beats emerge in order.
REQ-035 SHALL check rst asserted with 3 beats in flight: next cycle out_valid 0, data_out 0, no stale beat emerges afterwards.

Source files
------------

// File: rtl/pbs_pkg.sv
// Shared types and constants for the pipelined barrel shifter.
// Optional flag outputs are enabled with the PBS_FLAGS_EN macro.
package pbs_pkg;

  typedef enum logic [1:0] {
    MODE_LOGIC = 2'b00,
    MODE_ARITH = 2'b01,
    MODE_ROT   = 2'b10,
    MODE_RSVD  = 2'b11
  } shift_mode_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pbs_stage.sv
// One barrel-shifter level: conditional shift by STAGE_SHIFT followed by a register.
// Carry tracking ports exist only when PBS_FLAGS_EN is defined.
module pbs_stage
  import pbs_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int SHW         = 4,
  parameter int STAGE_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             pre_valid,
  input  logic             pre_dir,
  input  shift_mode_t      pre_mode,
  input  logic [SHW-1:0]   pre_amt,
  input  logic [WIDTH-1:0] pre_data,
`ifdef PBS_FLAGS_EN
  input  logic             pre_carry,
  input  logic             pre_force_en,
  input  logic             pre_force_val,
  output logic             post_carry,
  output logic             post_force_en,
  output logic             post_force_val,
`endif
  output logic             post_valid,
  output logic             post_dir,
  output shift_mode_t      post_mode,
  output logic [SHW-1:0]   post_amt,
  output logic [WIDTH-1:0] post_data
);

  localparam int AMT_BIT = $clog2(STAGE_SHIFT);

  logic             fill;
  logic [WIDTH-1:0] data_next;
  logic [SHW-1:0]   amt_next;

  logic             valid_reg;
  logic             dir_reg;
  shift_mode_t      mode_reg;
  logic [SHW-1:0]   amt_reg;
  logic [WIDTH-1:0] data_reg;

  // Each level consumes its own amount bit so later levels only see what remains.
  always_comb begin
    fill      = 1'b0;
    data_next = pre_data;
    amt_next  = pre_amt;
    amt_next[AMT_BIT] = 1'b0;
    if (pre_mode == MODE_ARITH && pre_dir == DIR_RIGHT) begin
      fill = pre_data[WIDTH-1];
    end
    if (pre_amt[AMT_BIT]) begin
      if (pre_mode == MODE_ROT) begin
        if (pre_dir == DIR_RIGHT) begin
          data_next = {pre_data[STAGE_SHIFT-1:0], pre_data[WIDTH-1:STAGE_SHIFT]};
        end else begin
          data_next = {pre_data[WIDTH-STAGE_SHIFT-1:0], pre_data[WIDTH-1:WIDTH-STAGE_SHIFT]};
        end
      end else if (pre_dir == DIR_RIGHT) begin
        data_next = {{STAGE_SHIFT{fill}}, pre_data[WIDTH-1:STAGE_SHIFT]};
      end else begin
        data_next = {pre_data[WIDTH-STAGE_SHIFT-1:0], {STAGE_SHIFT{1'b0}}};
      end
    end
  end

  // Payload only loads with a real beat, so bubbles leave the last value parked.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      dir_reg   <= DIR_LEFT;
      mode_reg  <= MODE_LOGIC;
      amt_reg   <= '0;
      data_reg  <= '0;
    end else if (adv) begin
      valid_reg <= pre_valid;
      if (pre_valid) begin
        dir_reg  <= pre_dir;
        mode_reg <= pre_mode;
        amt_reg  <= amt_next;
        data_reg <= data_next;
      end
    end
  end

  assign post_valid = valid_reg;
  assign post_dir   = dir_reg;
  assign post_mode  = mode_reg;
  assign post_amt   = amt_reg;
  assign post_data  = data_reg;

`ifdef PBS_FLAGS_EN
  logic carry_next;
  logic carry_reg;
  logic force_en_reg;
  logic force_val_reg;

  // The last level that actually moves data determines the final shifted-out bit.
  always_comb begin
    carry_next = pre_carry;
    if (pre_amt[AMT_BIT]) begin
      carry_next = (pre_dir == DIR_RIGHT) ? pre_data[STAGE_SHIFT-1]
                                          : pre_data[WIDTH-STAGE_SHIFT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_reg     <= 1'b0;
      force_en_reg  <= 1'b0;
      force_val_reg <= 1'b0;
    end else if (adv && pre_valid) begin
      carry_reg     <= carry_next;
      force_en_reg  <= pre_force_en;
      force_val_reg <= pre_force_val;
    end
  end

  assign post_carry     = carry_reg;
  assign post_force_en  = force_en_reg;
  assign post_force_val = force_val_reg;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: $clog2(WIDTH) registered mux levels with a global stall.
// Define PBS_FLAGS_EN to add the out_zero / out_carry flag outputs.
module pipelined_barrel_shifter
  import pbs_pkg::*;
#(
  parameter  int WIDTH = 12,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift_amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
`ifdef PBS_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  logic             adv;
  logic             valid_s [0:SHW];
  logic             dir_s   [0:SHW];
  shift_mode_t      mode_s  [0:SHW];
  logic [SHW-1:0]   amt_s   [0:SHW];
  logic [WIDTH-1:0] data_s  [0:SHW];

  // Every level moves together; a blocked output freezes the whole pipe.
  assign adv = !valid_s[SHW] || out_ready;

  assign valid_s[0] = in_valid;
  assign dir_s[0]   = dir;
  assign mode_s[0]  = shift_mode_t'(mode);
  assign amt_s[0]   = shift_amt;
  assign data_s[0]  = data_in;

`ifdef PBS_FLAGS_EN
  logic        carry_s     [0:SHW];
  logic        force_en_s  [0:SHW];
  logic        force_val_s [0:SHW];
  logic [31:0] amt_ext;
  logic        oversize;
  logic        wrap_zero;
  logic        is_rot;
  logic        arith_right;
  logic        force_en0;
  logic        force_val0;

  // Cases where the cascaded carry is wrong are decided up front and travel with the beat.
  always_comb begin
    amt_ext     = 32'(shift_amt);
    is_rot      = (shift_mode_t'(mode) == MODE_ROT);
    arith_right = (shift_mode_t'(mode) == MODE_ARITH) && (dir == DIR_RIGHT);
    oversize    = (amt_ext >= 32'(WIDTH));
    wrap_zero   = (amt_ext == 32'd0) || (amt_ext == 32'(WIDTH));
    force_en0   = (amt_ext == 32'd0) || (is_rot ? wrap_zero : oversize);
    force_val0  = !is_rot && oversize && arith_right && data_in[WIDTH-1];
  end

  assign carry_s[0]     = 1'b0;
  assign force_en_s[0]  = force_en0;
  assign force_val_s[0] = force_val0;
`endif

  for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
    pbs_stage #(
      .WIDTH       (WIDTH),
      .SHW         (SHW),
      .STAGE_SHIFT (1 << gi)
    ) u_stage (
      .clk            (clk),
      .rst            (rst),
      .adv            (adv),
      .pre_valid      (valid_s[gi]),
      .pre_dir        (dir_s[gi]),
      .pre_mode       (mode_s[gi]),
      .pre_amt        (amt_s[gi]),
      .pre_data       (data_s[gi]),
`ifdef PBS_FLAGS_EN
      .pre_carry      (carry_s[gi]),
      .pre_force_en   (force_en_s[gi]),
      .pre_force_val  (force_val_s[gi]),
      .post_carry     (carry_s[gi+1]),
      .post_force_en  (force_en_s[gi+1]),
      .post_force_val (force_val_s[gi+1]),
`endif
      .post_valid     (valid_s[gi+1]),
      .post_dir       (dir_s[gi+1]),
      .post_mode      (mode_s[gi+1]),
      .post_amt       (amt_s[gi+1]),
      .post_data      (data_s[gi+1])
    );
  end

  assign in_ready  = adv;
  assign out_valid = valid_s[SHW];
  assign data_out  = data_s[SHW];

`ifdef PBS_FLAGS_EN
  assign out_zero  = (data_s[SHW] == '0);
  assign out_carry = force_en_s[SHW] ? force_val_s[SHW] : carry_s[SHW];
`endif

  // Sideband of the final level has no consumer.
  logic unused_tail;
  assign unused_tail = ^{dir_s[SHW], mode_s[SHW], amt_s[SHW]};

endmodule
